// File: rtl/decode_unit_pkg.sv
// decode_unit_pkg: op classes, RV32 opcode/funct constants, decoded bundle and the decode function.
package decode_unit_pkg;
    localparam int REG_BITS = 4;

    typedef enum logic [3:0] {
        OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
        OP_LOAD, OP_STORE, OP_OP_IMM, OP_OP, OP_SYSTEM
    } op_class_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef struct packed {
        op_class_t           op;
        logic [REG_BITS-1:0] rd;
        logic [REG_BITS-1:0] rs1;
        logic [REG_BITS-1:0] rs2;
        logic [2:0]          funct3;
        logic                alt;
        logic [31:0]         imm;
        logic                illegal;
        logic [31:0]         raw;
    } decoded_t;

    function automatic logic reg_bad(input logic [4:0] r);
        return |(r >> REG_BITS);
    endfunction

    function automatic decoded_t decode(input logic [31:0] i, input logic fence_nop);
        decoded_t d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic use_rd, use_rs1, use_rs2, bad;
        f3 = i[14:12];
        f7 = i[31:25];
        d = '0;
        d.funct3 = f3;
        d.raw = i;
        use_rd = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        bad = 1'b0;
        case (i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                d.op = i[5] ? OP_LUI : OP_AUIPC;
                use_rd = 1'b1;
                d.imm = {i[31:12], 12'b0};
            end
            OPC_JAL: begin
                d.op = OP_JAL;
                use_rd = 1'b1;
                d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD: begin
                d.op = i[2] ? OP_JALR : OP_LOAD;
                use_rd = 1'b1;
                use_rs1 = 1'b1;
                d.imm = {{20{i[31]}}, i[31:20]};
                bad = !i[2] && !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
            end
            OPC_BRANCH: begin
                d.op = OP_BRANCH;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
                bad = f3[2:1] == 2'b01;
            end
            OPC_STORE: begin
                d.op = OP_STORE;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
                bad = !(f3 inside {F3_B, F3_H, F3_W});
            end
            OPC_OP_IMM: begin
                d.op = OP_OP_IMM;
                use_rd = 1'b1;
                use_rs1 = 1'b1;
                d.imm = {{20{i[31]}}, i[31:20]};
                d.alt = f3 == F3_SR ? i[30] : 1'b0;
                bad = f3 == F3_SLL ? f7 != F7_ZERO :
                      f3 == F3_SR  ? f7 != F7_ZERO && f7 != F7_ALT : 1'b0;
            end
            OPC_OP: begin
                d.op = OP_OP;
                use_rd = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                d.alt = i[30];
                bad = !(f7 == F7_ZERO || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
            end
            OPC_MISC_MEM: bad = !fence_nop;
            OPC_SYSTEM: begin
                d.op = OP_SYSTEM;
                d.imm = {{20{i[31]}}, i[31:20]};
                bad = i != ECALL && i != EBREAK;
            end
            default: bad = 1'b1;
        endcase
        d.rd  = use_rd  ? i[REG_BITS+6:7]   : '0;
        d.rs1 = use_rs1 ? i[REG_BITS+14:15] : '0;
        d.rs2 = use_rs2 ? i[REG_BITS+19:20] : '0;
        d.illegal = bad || i[1:0] != 2'b11 || (use_rd && reg_bad(i[11:7])) ||
                    (use_rs1 && reg_bad(i[19:15])) || (use_rs2 && reg_bad(i[24:20]));
        return d;
    endfunction
endpackage

// File: rtl/decode_unit_if.sv
// decode_unit_if: fetch-side word channel and execute-side decoded bundle channel.
interface decode_unit_if;
    import decode_unit_pkg::*;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_data;
    logic                out_valid;
    logic                out_ready;
    op_class_t           out_op;
    logic [REG_BITS-1:0] out_rd;
    logic [REG_BITS-1:0] out_rs1;
    logic [REG_BITS-1:0] out_rs2;
    logic [2:0]          out_funct3;
    logic                out_alt;
    logic [31:0]         out_imm;
    logic                out_illegal;
    logic [31:0]         out_raw;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
               out_funct3, out_alt, out_imm, out_illegal, out_raw
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
               out_funct3, out_alt, out_imm, out_illegal, out_raw
    );
endinterface

// File: rtl/decode_unit_skid_buffer.sv
// skid_buffer: 2-entry valid/ready buffer with registered in_ready and synchronous flush.
module skid_buffer #(
    parameter type T = logic [31:0]
) (
    input  logic clock,
    input  logic nreset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_next;
    T skid;
    logic in_fire, out_fire, load_main, load_skid, from_skid;

    assign in_ready  = state != FULL;
    assign out_valid = state != EMPTY;

    always_comb begin
        in_fire = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        load_main = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        state_next = state;
        case (state)
            EMPTY: begin
                load_main = in_fire;
                state_next = in_fire ? ONE : EMPTY;
            end
            ONE: begin
                load_main = in_fire && out_fire;
                load_skid = in_fire && !out_fire;
                state_next = load_skid ? FULL : (out_fire && !in_fire) ? EMPTY : ONE;
            end
            FULL: begin
                load_main = out_fire;
                from_skid = out_fire;
                state_next = out_fire ? ONE : FULL;
            end
            default: state_next = EMPTY;
        endcase
        if (flush) state_next = EMPTY;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= EMPTY;
            out_data <= '0;
            skid <= '0;
        end else begin
            state <= state_next;
            if (load_main) out_data <= from_skid ? skid : in_data;
            if (load_skid) skid <= in_data;
        end
    end
endmodule

// File: rtl/decode_unit.sv
// decode_unit: RV32E instruction decode registered into a 2-entry skid buffer toward execute.
module decode_unit
    import decode_unit_pkg::*;
#(
    parameter bit FENCE_AS_NOP = 1'b1
) (
    input logic          clock,
    input logic          nreset,
    input logic          flush,
    decode_unit_if.slave bus
);
    decoded_t d, q;

    assign d = decode(bus.in_data, FENCE_AS_NOP);

    skid_buffer #(.T(decoded_t)) u_skid (
        .clock     (clock),
        .nreset    (nreset),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (d),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (q)
    );

    assign bus.out_op      = q.op;
    assign bus.out_rd      = q.rd;
    assign bus.out_rs1     = q.rs1;
    assign bus.out_rs2     = q.rs2;
    assign bus.out_funct3  = q.funct3;
    assign bus.out_alt     = q.alt;
    assign bus.out_imm     = q.imm;
    assign bus.out_illegal = q.illegal;
    assign bus.out_raw     = q.raw;
endmodule

// File: tb/tb_decode_unit.sv
// tb_decode_unit: directed decode vectors plus backpressure, flush and async-reset sequences.
module tb_decode_unit;
  import decode_unit_pkg::*;
  logic clock, nreset, flush;
  int n_checks = 0;
  int n_fail = 0;
  localparam logic [31:0] W_ADDI = 32'hFFF10093;
  localparam logic [31:0] W_JAL  = 32'hFFDFF0EF;
  localparam logic [31:0] W_SW   = 32'h00512423;
  decode_unit_if bus();
  decode_unit dut (.clock(clock), .nreset(nreset), .flush(flush), .bus(bus));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic accept(input logic [31:0] w);
    bus.in_valid = 1'b1;
    bus.in_data = w;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask
  initial begin
    nreset = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    #2 nreset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_op", bus.out_op, OP_NOP);
    chk("rst_imm", bus.out_imm, 32'h0);
    chk("rst_raw", bus.out_raw, 32'h0);
    nreset = 1'b1;
    @(negedge clock);
    accept(W_ADDI);
    chk("addi_valid", bus.out_valid, 1'b1);
    chk("addi_op", bus.out_op, OP_OP_IMM);
    chk("addi_rd", bus.out_rd, 4'd1);
    chk("addi_rs1", bus.out_rs1, 4'd2);
    chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    chk("addi_ill", bus.out_illegal, 1'b0);
    accept(W_JAL);
    chk("jal_op", bus.out_op, OP_JAL);
    chk("jal_rd", bus.out_rd, 4'd1);
    chk("jal_imm", bus.out_imm, 32'hFFFFFFFC);
    accept(W_SW);
    chk("sw_op", bus.out_op, OP_STORE);
    chk("sw_rs1", bus.out_rs1, 4'd2);
    chk("sw_rs2", bus.out_rs2, 4'd5);
    chk("sw_imm", bus.out_imm, 32'h8);
    chk("sw_rd", bus.out_rd, 4'd0);
    chk("sw_f3", bus.out_funct3, 3'd2);
    accept(32'h00000833);
    chk("x16_ill", bus.out_illegal, 1'b1);
    chk("x16_raw", bus.out_raw, 32'h00000833);
    accept(32'h00000000);
    chk("low_bits_ill", bus.out_illegal, 1'b1);
    accept(32'h402081B3);
    chk("sub_op", bus.out_op, OP_OP);
    chk("sub_alt", bus.out_alt, 1'b1);
    chk("sub_imm", bus.out_imm, 32'h0);
    chk("sub_ill", bus.out_illegal, 1'b0);
    accept(32'h4030D093);
    chk("srai_alt", bus.out_alt, 1'b1);
    chk("srai_ill", bus.out_illegal, 1'b0);
    accept(32'h02208033);
    chk("mul_ill", bus.out_illegal, 1'b1);
    accept(32'h00209863);
    chk("bne_op", bus.out_op, OP_BRANCH);
    chk("bne_imm", bus.out_imm, 32'h10);
    chk("bne_rd", bus.out_rd, 4'd0);
    accept(32'h00002063);
    chk("br_f3_ill", bus.out_illegal, 1'b1);
    accept(32'h123452B7);
    chk("lui_op", bus.out_op, OP_LUI);
    chk("lui_rd", bus.out_rd, 4'd5);
    chk("lui_imm", bus.out_imm, 32'h12345000);
    accept(32'h00000073);
    chk("ecall_op", bus.out_op, OP_SYSTEM);
    chk("ecall_ill", bus.out_illegal, 1'b0);
    accept(32'h10500073);
    chk("wfi_ill", bus.out_illegal, 1'b1);
    accept(32'h0FF0000F);
    chk("fence_op", bus.out_op, OP_NOP);
    chk("fence_ill", bus.out_illegal, 1'b0);
    @(negedge clock);
    chk("drain_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = W_ADDI;
    @(negedge clock);
    chk("bp_ready_one", bus.in_ready, 1'b1);
    bus.in_data = W_JAL;
    @(negedge clock);
    chk("bp_ready_full", bus.in_ready, 1'b0);
    chk("bp_head_a", bus.out_raw, W_ADDI);
    bus.in_data = W_SW;
    @(negedge clock);
    chk("bp_ready_held", bus.in_ready, 1'b0);
    chk("bp_stable_a", bus.out_raw, W_ADDI);
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("bp_out_b", bus.out_raw, W_JAL);
    chk("bp_valid_b", bus.out_valid, 1'b1);
    @(negedge clock);
    bus.in_valid = 1'b0;
    chk("bp_out_c", bus.out_raw, W_SW);
    chk("bp_valid_c", bus.out_valid, 1'b1);
    @(negedge clock);
    chk("bp_empty", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = W_ADDI;
    @(negedge clock);
    bus.in_data = W_JAL;
    @(negedge clock);
    chk("fl_full", bus.in_ready, 1'b0);
    bus.in_data = W_SW;
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_valid", bus.out_valid, 1'b0);
    chk("fl_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("fl_no_c", bus.out_valid, 1'b0);
    end
    accept(W_SW);
    chk("fl_after_raw", bus.out_raw, W_SW);
    @(negedge clock);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = W_ADDI;
    @(negedge clock);
    bus.in_data = W_JAL;
    @(negedge clock);
    bus.in_valid = 1'b0;
    chk("rm_full", bus.in_ready, 1'b0);
    nreset = 1'b0;
    #1;
    chk("rm_async_valid", bus.out_valid, 1'b0);
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    chk("rm_ready", bus.in_ready, 1'b1);
    chk("rm_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("rm_no_out", bus.out_valid, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
